tbd_accel_seq: RTL and testbench

//  Job sequencer for the tbd_accel pattern-match accelerator in the user domain.
//  - Software queues buffer base addresses through the MMIO front-end. This block launches
//    one accelerator run per queued job and guards each run with a watchdog.
//  - It accumulates done/match statistics and raises an interrupt when the queue drains.
//  - Sits between the user-domain MMIO register block and tbd_accel, replacing the direct

---
 rtl/user_pkg.sv | 20 ++
 rtl/accel_job_fifo.sv | 73 +++++++
 rtl/tbd_accel_seq.sv | 184 ++++++++++++++++++
 tb/tb_tbd_accel_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_pkg.sv
// ---------------------------------------------------------------------------
// user_pkg
// Shared types and defaults for the tbd_accel job sequencer.
//   accel_seq_state_e  : sequencer FSM encoding
//   AccelSeqFifoDepth  : default job queue depth
//   AccelSeqCntWidth   : default statistics counter width
// ---------------------------------------------------------------------------
package user_pkg;

  typedef enum logic [1:0] {
    SeqIdle  = 2'd0,
    SeqRun   = 2'd1,
    SeqDrain = 2'd2,
    SeqError = 2'd3
  } accel_seq_state_e;

  localparam int AccelSeqFifoDepth = 4;
  localparam int AccelSeqCntWidth  = 16;

endpackage

// File: rtl/accel_job_fifo.sv
// ---------------------------------------------------------------------------
// accel_job_fifo
// Small job queue with fall-through head data.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : empty the queue (overrides push/pop)
//   push, data  : write request and job word (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   full, empty : status flags
//   usage       : current occupancy
//   head        : oldest entry, valid while !empty
// ---------------------------------------------------------------------------
module accel_job_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [Width-1:0]         data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   usage,
  output logic [Width-1:0]         head
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PtrW+1)'(Depth));
  assign empty   = (count == '0);
  assign usage   = count;
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer, occupancy and storage update; Depth is a power of two so the
  // pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (rst) begin
        for (int i = 0; i < Depth; i++) begin
          mem[i] <= '0;
        end
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PtrW+1)'(1);
        2'b01:   count <= count - (PtrW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tbd_accel_seq.sv
// ---------------------------------------------------------------------------
// tbd_accel_seq
// Launches one tbd_accel run per queued job base address, guards each run
// with a watchdog, keeps done/match statistics and pulses irq_o when the
// queue drains.
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   en_i                      : launch enable (current job always finishes)
//   clear_i                   : flush queue, zero counters/err/last_match
//   job_valid_i, job_addr_i   : job push; job_ready_o = queue not full
//   accel_base_o/start_o      : address and level start to tbd_accel
//   accel_done_i/match_i      : level done and match result from tbd_accel
//   busy_o, queue_lvl_o       : activity and queue occupancy
//   jobs_done_o, match_cnt_o  : saturating statistics
//   last_match_o, err_o       : last result, sticky timeout flag
//   irq_o                     : one-cycle queue-drained pulse
// ---------------------------------------------------------------------------
module tbd_accel_seq
  import user_pkg::*;
#(
  parameter int AddrWidth     = 32,
  parameter int FifoDepth     = AccelSeqFifoDepth,
  parameter int CntWidth      = AccelSeqCntWidth,
  parameter int TimeoutCycles = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       clear_i,
  input  logic                       job_valid_i,
  input  logic [AddrWidth-1:0]       job_addr_i,
  output logic                       job_ready_o,
  output logic [AddrWidth-1:0]       accel_base_o,
  output logic                       accel_start_o,
  input  logic                       accel_done_i,
  input  logic                       accel_match_i,
  output logic                       busy_o,
  output logic [$clog2(FifoDepth):0] queue_lvl_o,
  output logic [CntWidth-1:0]        jobs_done_o,
  output logic [CntWidth-1:0]        match_cnt_o,
  output logic                       last_match_o,
  output logic                       err_o,
  output logic                       irq_o
);

  localparam int LvlW   = $clog2(FifoDepth) + 1;
  localparam int TimerW = $clog2(TimeoutCycles);

  accel_seq_state_e     state;
  accel_seq_state_e     next_state;
  logic [TimerW-1:0]    timer;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LvlW-1:0]      fifo_lvl;
  logic [AddrWidth-1:0] fifo_head;
  logic                 push;
  logic                 pop;
  logic                 pop_eff;
  logic                 launch;
  logic                 run_done;
  logic                 run_timeout;
  logic                 irq_next;

  // A push coinciding with clear is dropped.
  assign push = job_valid_i && !fifo_full && !clear_i;
  // Pop only really happens when the queue still holds the job (clear may
  // have flushed it while the job was running).
  assign pop_eff  = pop && !fifo_empty && !clear_i;
  assign irq_next = pop_eff && !push && (fifo_lvl == LvlW'(1));

  assign job_ready_o = !fifo_full;
  assign queue_lvl_o = fifo_lvl;
  assign busy_o      = (state != SeqIdle) || !fifo_empty;

  accel_job_fifo #(
    .Width (AddrWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (clear_i),
    .push  (push),
    .data  (job_addr_i),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .usage (fifo_lvl),
    .head  (fifo_head)
  );

  // Next-state and per-cycle event decode.
  always_comb begin
    next_state  = state;
    launch      = 1'b0;
    pop         = 1'b0;
    run_done    = 1'b0;
    run_timeout = 1'b0;
    case (state)
      SeqIdle: begin
        if (en_i && !fifo_empty && !clear_i) begin
          next_state = SeqRun;
          launch     = 1'b1;
        end else begin
          next_state = SeqIdle;
        end
      end
      SeqRun: begin
        if (accel_done_i) begin
          run_done   = 1'b1;
          pop        = 1'b1;
          next_state = SeqDrain;
        end else if (timer == TimerW'(TimeoutCycles - 1)) begin
          run_timeout = 1'b1;
          pop         = 1'b1;
          next_state  = SeqError;
        end else begin
          next_state = SeqRun;
        end
      end
      SeqDrain: begin
        if (!accel_done_i) begin
          next_state = SeqIdle;
        end else begin
          next_state = SeqDrain;
        end
      end
      SeqError: begin
        if (clear_i) begin
          next_state = SeqIdle;
        end else begin
          next_state = SeqError;
        end
      end
      default: next_state = SeqIdle;
    endcase
  end

  // State, watchdog, accelerator interface and irq registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= SeqIdle;
      timer         <= '0;
      accel_base_o  <= '0;
      accel_start_o <= 1'b0;
      irq_o         <= 1'b0;
    end else begin
      state         <= next_state;
      accel_start_o <= (next_state == SeqRun);
      irq_o         <= irq_next;
      if (launch) begin
        accel_base_o <= fifo_head;
      end
      if ((state == SeqRun) && (next_state == SeqRun)) begin
        timer <= timer + TimerW'(1);
      end else begin
        timer <= '0;
      end
    end
  end

  // Statistics; clear wins over a completion in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      jobs_done_o  <= '0;
      match_cnt_o  <= '0;
      last_match_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      if ((run_done || run_timeout) && (jobs_done_o != {CntWidth{1'b1}})) begin
        jobs_done_o <= jobs_done_o + CntWidth'(1);
      end
      if (run_done && accel_match_i && (match_cnt_o != {CntWidth{1'b1}})) begin
        match_cnt_o <= match_cnt_o + CntWidth'(1);
      end
      if (run_done) begin
        last_match_o <= accel_match_i;
      end
      if (run_timeout) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tbd_accel_seq.sv
// ---------------------------------------------------------------------------
// tb_tbd_accel_seq
// Directed bench for tbd_accel_seq with a small behavioural accelerator:
// done rises on the third start-high cycle (unless stalled) and falls after
// start drops plus an optional hold.
// ---------------------------------------------------------------------------
module tb_tbd_accel_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clear;
  logic        job_valid;
  logic [31:0] job_addr;
  logic        job_ready;
  logic [31:0] accel_base;
  logic        accel_start;
  logic        accel_done;
  logic        accel_match;
  logic        busy;
  logic [2:0]  queue_lvl;
  logic [15:0] jobs_done;
  logic [15:0] match_cnt;
  logic        last_match;
  logic        err;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  // accelerator model controls (written by the stimulus only)
  logic model_never = 1'b0;
  logic model_match = 1'b0;
  int   model_hold  = 0;

  // model / monitor state (written by the negedge block only)
  int          run_cnt = 0;
  int          hold_left = 0;
  int          cyc = 0;
  int          start_cycles = 0;
  int          irq_cnt = 0;
  logic        prev_start = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] launched[$];
  int          rise_cyc[$];
  int          fall_cyc[$];

  always #5 clk = ~clk;

  tbd_accel_seq #(
    .AddrWidth     (32),
    .FifoDepth     (4),
    .CntWidth      (16),
    .TimeoutCycles (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .clear_i       (clear),
    .job_valid_i   (job_valid),
    .job_addr_i    (job_addr),
    .job_ready_o   (job_ready),
    .accel_base_o  (accel_base),
    .accel_start_o (accel_start),
    .accel_done_i  (accel_done),
    .accel_match_i (accel_match),
    .busy_o        (busy),
    .queue_lvl_o   (queue_lvl),
    .jobs_done_o   (jobs_done),
    .match_cnt_o   (match_cnt),
    .last_match_o  (last_match),
    .err_o         (err),
    .irq_o         (irq)
  );

  // accelerator model followed by the launch/irq monitor
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      accel_done  = 1'b0;
      accel_match = 1'b0;
      run_cnt     = 0;
      hold_left   = 0;
    end else if (accel_start) begin
      if (!model_never && !accel_done) begin
        run_cnt = run_cnt + 1;
        if (run_cnt >= 3) begin
          accel_done  = 1'b1;
          accel_match = model_match;
          hold_left   = model_hold;
        end
      end
    end else begin
      run_cnt = 0;
      if (accel_done) begin
        if (hold_left > 0) begin
          hold_left = hold_left - 1;
        end else begin
          accel_done  = 1'b0;
          accel_match = 1'b0;
        end
      end
    end
    if (accel_start) start_cycles = start_cycles + 1;
    if (accel_start && !prev_start) begin
      launched.push_back(accel_base);
      rise_cyc.push_back(cyc);
    end
    if (!accel_done && prev_done) fall_cyc.push_back(cyc);
    if (irq) irq_cnt = irq_cnt + 1;
    prev_start = accel_start;
    prev_done  = accel_done;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_job(input logic [31:0] addr);
    job_valid = 1'b1;
    job_addr  = addr;
    tick(1);
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check_val(tag, {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!accel_start && n < budget) begin
      tick(1);
      n++;
    end
    check_val("start_seen", {63'd0, accel_start}, 64'd1);
  endtask

  initial begin
    int n0;
    int f0;
    int i0;
    int sc0;
    int n;
    logic [31:0] exp_addr;

    rst = 1'b1; en = 1'b0; clear = 1'b0; job_valid = 1'b0; job_addr = 32'd0;
    tick(3);
    // reset state (rst still asserted)
    check_val("rst_ready", {63'd0, job_ready}, 64'd1);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_lvl", {61'd0, queue_lvl}, 64'd0);
    check_val("rst_start", {63'd0, accel_start}, 64'd0);
    check_val("rst_base", {32'd0, accel_base}, 64'd0);
    check_val("rst_stats", {30'd0, jobs_done, match_cnt, last_match, err}, 64'd0);
    check_val("rst_irq", {63'd0, irq}, 64'd0);
    rst = 1'b0;
    tick(1);

    // 1: single job, latency and statistics
    en = 1'b1; model_match = 1'b1;
    i0 = irq_cnt;
    push_job(32'h1000_0040);
    check_val("t1_lvl", {61'd0, queue_lvl}, 64'd1);
    check_val("t1_start_early", {63'd0, accel_start}, 64'd0);
    tick(1);
    check_val("t1_start_p2", {63'd0, accel_start}, 64'd1);
    check_val("t1_base", {32'd0, accel_base}, 64'h1000_0040);
    wait_idle("t1_idle", 50);
    check_val("t1_jobs", {48'd0, jobs_done}, 64'd1);
    check_val("t1_match", {48'd0, match_cnt}, 64'd1);
    check_val("t1_last", {63'd0, last_match}, 64'd1);
    check_val("t1_irq", irq_cnt - i0, 64'd1);

    // 2: fill queue with launches disabled, then drain in order
    en = 1'b0; model_match = 1'b0;
    for (int i = 0; i < 5; i++) begin
      job_valid = 1'b1;
      job_addr  = 32'h2000_0000 + 32'(i) * 32'h100;
      if (i == 4) begin
        check_val("t2_ready_full", {63'd0, job_ready}, 64'd0);
        check_val("t2_lvl_full", {61'd0, queue_lvl}, 64'd4);
      end
      tick(1);
    end
    job_valid = 1'b0;
    check_val("t2_lvl_after", {61'd0, queue_lvl}, 64'd4);
    check_val("t2_no_start", {63'd0, accel_start}, 64'd0);
    n0 = launched.size();
    i0 = irq_cnt;
    en = 1'b1;
    wait_idle("t2_idle", 200);
    check_val("t2_runs", launched.size() - n0, 64'd4);
    for (int i = 0; i < 4; i++) begin
      exp_addr = 32'h2000_0000 + 32'(i) * 32'h100;
      if (n0 + i < launched.size()) check_val("t2_order", {32'd0, launched[n0+i]}, {32'd0, exp_addr});
    end
    check_val("t2_jobs", {48'd0, jobs_done}, 64'd5);
    check_val("t2_match", {48'd0, match_cnt}, 64'd1);
    check_val("t2_irq", irq_cnt - i0, 64'd1);

    // 3: watchdog timeout blocks further launches until clear
    model_never = 1'b1;
    sc0 = start_cycles;
    n0 = launched.size();
    push_job(32'h3000_0000);
    push_job(32'h3000_0100);
    n = 0;
    while (!err && n < 100) begin
      tick(1);
      n++;
    end
    tick(2);
    check_val("t3_err", {63'd0, err}, 64'd1);
    check_val("t3_start_cycles", start_cycles - sc0, 64'd16);
    check_val("t3_jobs", {48'd0, jobs_done}, 64'd6);
    check_val("t3_lvl", {61'd0, queue_lvl}, 64'd1);
    check_val("t3_busy", {63'd0, busy}, 64'd1);
    tick(10);
    check_val("t3_blocked", launched.size() - n0, 64'd1);
    model_never = 1'b0;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_val("t3_clr_stats", {30'd0, jobs_done, match_cnt, last_match, err}, 64'd0);
    check_val("t3_clr_lvl", {61'd0, queue_lvl}, 64'd0);
    tick(2);
    check_val("t3_clr_idle", {63'd0, busy}, 64'd0);
    check_val("t3_clr_nolaunch", launched.size() - n0, 64'd1);

    // 4: clear while running with two jobs behind the active one
    model_match = 1'b1;
    en = 1'b0;
    push_job(32'h4000_0000);
    push_job(32'h4000_0100);
    push_job(32'h4000_0200);
    n0 = launched.size();
    en = 1'b1;
    wait_start(20);
    check_val("t4_lvl_run", {61'd0, queue_lvl}, 64'd3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_val("t4_clr_lvl", {61'd0, queue_lvl}, 64'd0);
    check_val("t4_clr_jobs", {48'd0, jobs_done}, 64'd0);
    wait_idle("t4_idle", 50);
    check_val("t4_jobs", {48'd0, jobs_done}, 64'd1);
    check_val("t4_match", {48'd0, match_cnt}, 64'd1);
    check_val("t4_launches", launched.size() - n0, 64'd1);

    // 5: done held after start drops; relaunch waits for it to fall
    model_hold = 5;
    en = 1'b0;
    push_job(32'h5000_0000);
    push_job(32'h5000_0100);
    n0 = launched.size();
    f0 = fall_cyc.size();
    en = 1'b1;
    wait_idle("t5_idle", 200);
    check_val("t5_launches", launched.size() - n0, 64'd2);
    if (launched.size() >= n0 + 2 && fall_cyc.size() > f0) begin
      check_val("t5_relaunch_gap", rise_cyc[n0+1] - fall_cyc[f0], 64'd2);
      check_val("t5_addr2", {32'd0, launched[n0+1]}, 64'h5000_0100);
    end
    model_hold = 0;

    // 6: push coinciding with the last pop suppresses irq
    i0 = irq_cnt;
    n0 = launched.size();
    push_job(32'h6000_0000);
    n = 0;
    while (!accel_done && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("t6_done_seen", {63'd0, accel_done}, 64'd1);
    job_valid = 1'b1;
    job_addr  = 32'h6000_0100;
    tick(1);
    job_valid = 1'b0;
    check_val("t6_lvl", {61'd0, queue_lvl}, 64'd1);
    tick(2);
    check_val("t6_no_irq", irq_cnt - i0, 64'd0);
    wait_idle("t6_idle", 50);
    check_val("t6_irq", irq_cnt - i0, 64'd1);
    check_val("t6_launches", launched.size() - n0, 64'd2);
    if (launched.size() >= n0 + 2) check_val("t6_addr2", {32'd0, launched[n0+1]}, 64'h6000_0100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
